// File: rtl/somador_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder/subtractor.
package somador_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int unsigned MAX_STAGES = 8;

    // Chunk width per stage; returns 0 for an illegal WIDTH/STAGES pair.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        if (stages == 0 || stages > MAX_STAGES || (width % stages) != 0)
            return 0;
        return width / stages;
    endfunction

endpackage

// File: rtl/somador_estagio.sv
// One pipeline stage: adds its operand chunk plus the incoming carry and
// holds the partial result until the next stage can take it.
module somador_estagio #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 16,
    parameter int unsigned IDX   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             ready_c,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_carry,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_res,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_ovf
);

    localparam int unsigned LO   = IDX * CHUNK;
    localparam int unsigned SUMW = CHUNK + 1;

    logic [CHUNK:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             zero_c;
    logic             ovf_c;
    logic             load_c;

    // Chunk add; overflow is only meaningful once the MSB chunk is in place.
    always_comb begin
        sum_c  = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]} + SUMW'(in_carry);
        res_c  = in_res;
        res_c[LO +: CHUNK] = sum_c[CHUNK-1:0];
        zero_c = in_zero && (sum_c[CHUNK-1:0] == '0);
        ovf_c  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_c[WIDTH-1] != in_a[WIDTH-1]);
    end

    assign ready_c = !out_valid || out_ready;
    assign load_c  = in_valid && ready_c;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_res   <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (ready_c)
                out_valid <= in_valid;
            if (load_c) begin
                out_a     <= in_a;
                out_b     <= in_b;
                out_res   <= res_c;
                out_carry <= sum_c[CHUNK];
                out_zero  <= zero_c;
                out_ovf   <= ovf_c;
            end
        end
    end

endmodule

// File: rtl/somador_pipelinado.sv
// Pipelined adder/subtractor: WIDTH split into STAGES chunks with the carry
// rippled stage to stage, valid/ready handshake with full backpressure.
module somador_pipelinado
    import somador_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] entrada1,
    input  logic [WIDTH-1:0] entrada2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultado,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    if (CHUNK == 0) begin : g_bad_params
        $error("somador_pipelinado: WIDTH must be divisible by STAGES, STAGES in 1..8");
    end

    // Index k is the input side of stage k; index STAGES is the output register.
    logic [STAGES:0]  v_s;
    logic [STAGES:0]  rdy_s;
    logic [WIDTH-1:0] a_s   [0:STAGES];
    logic [WIDTH-1:0] b_s   [0:STAGES];
    logic [WIDTH-1:0] r_s   [0:STAGES];
    logic [STAGES:0]  c_s;
    logic [STAGES:0]  z_s;
    logic [STAGES-1:0] ovf_s;

    // Subtract as A + ~B + 1: the +1 enters as the stage-0 carry.
    assign v_s[0]         = in_valid;
    assign a_s[0]         = entrada1;
    assign b_s[0]         = (op == OP_SUB) ? ~entrada2 : entrada2;
    assign r_s[0]         = '0;
    assign c_s[0]         = (op == OP_SUB);
    assign z_s[0]         = 1'b1;
    assign rdy_s[STAGES]  = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        somador_estagio #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_estagio (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (v_s[k]),
            .ready_c   (rdy_s[k]),
            .in_a      (a_s[k]),
            .in_b      (b_s[k]),
            .in_res    (r_s[k]),
            .in_carry  (c_s[k]),
            .in_zero   (z_s[k]),
            .out_valid (v_s[k+1]),
            .out_ready (rdy_s[k+1]),
            .out_a     (a_s[k+1]),
            .out_b     (b_s[k+1]),
            .out_res   (r_s[k+1]),
            .out_carry (c_s[k+1]),
            .out_zero  (z_s[k+1]),
            .out_ovf   (ovf_s[k])
        );
    end

    assign in_ready  = rdy_s[0] && !reset;
    assign out_valid = v_s[STAGES];
    assign resultado = r_s[STAGES];
    assign carry     = c_s[STAGES];
    assign zero      = z_s[STAGES];
    assign negative  = r_s[STAGES][WIDTH-1];
    assign overflow  = ovf_s[STAGES-1];

    // Operand copies past the last stage and early-stage overflow bits are dead.
    logic unused_bits;
    assign unused_bits = ^{a_s[STAGES], b_s[STAGES], ovf_s};

endmodule

// File: tb/tb_somador_pipelinado.sv
// Scoreboard bench: directed 32-bit/2-stage vectors plus an 8-bit sweep over
// STAGES = 1, 2, 4, 8 against a behavioural model.
`timescale 1ns/1ps
module tb_somador_pipelinado;
    import somador_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned ST   = 2;
    localparam int unsigned SW   = 8;
    localparam int unsigned NOPS = 1000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset, in_valid, in_ready, op, out_valid, out_ready;
    logic         carry, overflow, zero, negative;
    logic [W-1:0] entrada1, entrada2, resultado;
    logic         rst_sw = 1'b1;

    typedef struct {
        logic [31:0] res;
        logic        c, v, z, n;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nfail = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    somador_pipelinado #(.WIDTH(W), .STAGES(ST)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .entrada1  (entrada1),
        .entrada2  (entrada2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resultado (resultado),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    // Monitor: pops on every output transfer, and checks stability while stalled.
    logic          stalled = 1'b0;
    logic [W+3:0]  held = '0;
    always @(negedge clock) begin : mon_main
        exp_t e;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("stall_hold", {resultado, carry, overflow, zero, negative}, held);
            stalled = out_valid && !out_ready;
            held    = {resultado, carry, overflow, zero, negative};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_out", {32'd0, resultado}, 64'hDEAD_0000_0000);
                end else begin
                    e = q.pop_front();
                    check("resultado", resultado, e.res);
                    check("flags_cvzn", {carry, overflow, zero, negative}, {e.c, e.v, e.z, e.n});
                    if (e.chk_lat)
                        check("latency", 64'(cyc - e.cyc), ST);
                end
            end
        end
    end

    // Present one operation; called #1 after a rising edge, returns #1 after its accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] r, input logic c, input logic v,
                        input logic z, input logic n, input bit lat, input bit keep);
        exp_t e;
        entrada1 = a;
        entrada2 = b;
        op       = o;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clock);
            if (in_ready) begin
                e.res = r; e.c = c; e.v = v; e.z = z; e.n = n;
                e.cyc = cyc; e.chk_lat = lat;
                if (keep)
                    q.push_back(e);
                @(posedge clock); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        check("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_empty();
        for (int t = 0; t < 200; t++) begin
            if (q.size() == 0)
                break;
            @(posedge clock);
        end
        #1;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    // 8-bit sweep: one DUT per stage count, random traffic, no backpressure.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int unsigned NST = 1 << g;
        logic          iv, ir, o, ov, c, v, z, n;
        logic [SW-1:0] a, b, r;
        exp_t          sq[$];
        bit            done = 1'b0;

        somador_pipelinado #(.WIDTH(SW), .STAGES(NST)) u_dut (
            .clock     (clock),
            .reset     (rst_sw),
            .in_valid  (iv),
            .in_ready  (ir),
            .entrada1  (a),
            .entrada2  (b),
            .op        (o),
            .out_valid (ov),
            .out_ready (1'b1),
            .resultado (r),
            .carry     (c),
            .overflow  (v),
            .zero      (z),
            .negative  (n)
        );

        initial begin : drv
            exp_t          e;
            logic [8:0]    full;
            int            s;
            iv = 1'b0; a = '0; b = '0; o = OP_ADD;
            wait (rst_sw == 1'b0);
            @(posedge clock); #1;
            for (int i = 0; i < int'(NOPS); i++) begin
                iv = ($urandom_range(3) != 0);
                a  = 8'($urandom);
                b  = 8'($urandom);
                o  = 1'($urandom);
                @(negedge clock);
                if (iv) begin
                    check($sformatf("sw%0d_in_ready", NST), {63'd0, ir}, 64'd1);
                    if (o == OP_SUB) begin
                        e.res = 32'(8'(a - b));
                        e.c   = (a >= b);
                        s     = int'($signed(a)) - int'($signed(b));
                    end else begin
                        full  = 9'(a) + 9'(b);
                        e.res = 32'(full[7:0]);
                        e.c   = full[8];
                        s     = int'($signed(a)) + int'($signed(b));
                    end
                    e.v = (s > 127) || (s < -128);
                    e.z = (e.res[7:0] == 8'd0);
                    e.n = e.res[7];
                    e.cyc = cyc;
                    e.chk_lat = 1'b1;
                    if (ir)
                        sq.push_back(e);
                end
                @(posedge clock); #1;
            end
            iv = 1'b0;
            for (int t = 0; t < 50; t++) begin
                if (sq.size() == 0)
                    break;
                @(posedge clock);
            end
            check($sformatf("sw%0d_drain", NST), 64'(sq.size()), 64'd0);
            done = 1'b1;
        end

        always @(negedge clock) begin : mon
            exp_t m;
            if (!rst_sw && ov) begin
                if (sq.size() == 0) begin
                    check($sformatf("sw%0d_unexpected", NST), {56'd0, r}, 64'hDEAD_0000_0000);
                end else begin
                    m = sq.pop_front();
                    check($sformatf("sw%0d_res", NST), r, m.res[7:0]);
                    check($sformatf("sw%0d_flags", NST), {c, v, z, n}, {m.c, m.v, m.z, m.n});
                    check($sformatf("sw%0d_latency", NST), 64'(cyc - m.cyc), NST);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
        entrada1 = '0; entrada2 = '0;
        idle(2);
        @(negedge clock);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_resultado", resultado, 64'd0);
        check("rst_flags", {carry, overflow, zero, negative}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        rst_sw = 1'b0;

        // Directed arithmetic, back to back, latency checked.
        send(32'h0000_0001, 32'h0000_0003, OP_ADD, 32'h0000_0004, 0, 0, 0, 0, 1, 1);
        send(32'h0000_0003, 32'h0000_0001, OP_SUB, 32'h0000_0002, 1, 0, 0, 0, 1, 1);
        send(32'h0000_0001, 32'h0000_0003, OP_SUB, 32'hFFFF_FFFE, 0, 0, 0, 1, 1, 1);
        send(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1, 0, 1, 0, 1, 1);
        send(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 0, 1, 0, 1, 1, 1);
        send(32'h0000_FFFF, 32'h0000_0001, OP_ADD, 32'h0001_0000, 0, 0, 0, 0, 1, 1);
        send(32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1, 1, 0, 0, 1, 1);
        send(32'h1234_5678, 32'h1234_5678, OP_SUB, 32'h0000_0000, 1, 0, 1, 0, 1, 1);
        wait_empty();

        // Backpressure: fill both stages, then release and expect one result per cycle.
        out_ready = 1'b0;
        send(32'd1, 32'd1, OP_ADD, 32'd2, 0, 0, 0, 0, 0, 1);
        send(32'd2, 32'd2, OP_ADD, 32'd4, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_head", resultado, 64'd2);
        @(posedge clock); #1;
        fork
            begin
                send(32'd3, 32'd3, OP_ADD, 32'd6, 0, 0, 0, 0, 0, 1);
                send(32'd4, 32'd4, OP_ADD, 32'd8, 0, 0, 0, 0, 0, 1);
            end
            begin
                idle(2);
                out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clock);
                    check("bp_one_per_cycle", {63'd0, out_valid}, 64'd1);
                end
            end
        join
        wait_empty();

        // Reset with two operations in flight: neither may ever emerge.
        out_ready = 1'b0;
        send(32'd10, 32'd20, OP_ADD, 32'd30, 0, 0, 0, 0, 0, 0);
        send(32'd30, 32'd40, OP_ADD, 32'd70, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_resultado", resultado, 64'd0);
        check("mid_rst_flags", {carry, overflow, zero, negative}, 64'd0);
        @(posedge clock); #1;
        send(32'd5, 32'd6, OP_ADD, 32'd11, 0, 0, 0, 0, 1, 1);
        idle(6);
        wait_empty();

        for (int t = 0; t < 20000; t++) begin
            if (g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)
                break;
            @(posedge clock);
        end
        check("sweep_done", {60'd0, g_sw[3].done, g_sw[2].done, g_sw[1].done, g_sw[0].done}, 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
